// File: rtl/jcr_seq_irq_unit_if.sv
// Control/status bundle between the jacaranda core decode path and the
// program-sequencing/interrupt unit.
interface jcr_seq_irq_unit_if #(
    parameter int PC_W       = 8,
    parameter int N_IRQ      = 4,
    parameter int NEST_DEPTH = 2
);
    localparam int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam int LVL_W = $clog2(NEST_DEPTH + 1);

    logic                    jmp_en;
    logic                    je_en;
    logic                    ret;
    logic                    flag_w_en;
    logic                    flag_in;
    logic [PC_W-1:0]         target;
    logic [N_IRQ-1:0]        irq_req;
    logic [N_IRQ-1:0]        irq_en;
    logic                    global_en;
    logic [N_IRQ*PC_W-1:0]   irq_vec;
    logic [PC_W-1:0]         pc;
    logic                    flag;
    logic                    in_isr;
    logic [LVL_W-1:0]        level;
    logic [ID_W-1:0]         active_id;
    logic [N_IRQ-1:0]        irq_ack;
    logic                    ret_err;

    modport master (
        output jmp_en, je_en, ret, flag_w_en, flag_in, target,
               irq_req, irq_en, global_en, irq_vec,
        input  pc, flag, in_isr, level, active_id, irq_ack, ret_err
    );

    modport slave (
        input  jmp_en, je_en, ret, flag_w_en, flag_in, target,
               irq_req, irq_en, global_en, irq_vec,
        output pc, flag, in_isr, level, active_id, irq_ack, ret_err
    );
endinterface

// File: rtl/jcr_seq_irq_unit.sv
// Program sequencer for the jacaranda core: PC, branch flag, vectored
// prioritised interrupts and a nested return stack with tail-chaining.
module jcr_seq_irq_unit #(
    parameter int PC_W       = 8,
    parameter int N_IRQ      = 4,
    parameter int NEST_DEPTH = 2
) (
    input logic          clock,
    input logic          reset,
    jcr_seq_irq_unit_if.slave bus
);
    localparam int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam int LVL_W = $clog2(NEST_DEPTH + 1);
    localparam int IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
    localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(NEST_DEPTH);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic             flag_q, flag_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [ID_W-1:0]  active_id_q, active_id_d;
    logic [N_IRQ-1:0] irq_ack_q, irq_ack_d;
    logic             ret_err_q, ret_err_d;

    logic [PC_W-1:0]  stk_pc_q   [NEST_DEPTH];
    logic             stk_flag_q [NEST_DEPTH];
    logic [ID_W-1:0]  stk_id_q   [NEST_DEPTH];

    logic             ret_ok;
    logic             push;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;
    logic [PC_W-1:0]  pop_pc;
    logic             pop_flag;
    logic [ID_W-1:0]  pop_id;
    logic [PC_W-1:0]  seq_pc;
    logic             flag_next;
    logic             cand_vld;
    logic [ID_W-1:0]  cand;
    logic             ceil_vld;
    logic [ID_W-1:0]  ceil_id;
    logic [LVL_W-1:0] eff_level;
    logic             take;

    always_comb begin
        ret_ok   = bus.ret && (level_q != '0);
        push_idx = IDX_W'(level_q);
        pop_idx  = IDX_W'(level_q - LVL_W'(1));

        pop_pc   = '0;
        pop_flag = 1'b0;
        pop_id   = '0;
        if (level_q != '0) begin
            pop_pc   = stk_pc_q[pop_idx];
            pop_flag = stk_flag_q[pop_idx];
            pop_id   = stk_id_q[pop_idx];
        end

        // A valid return owns the flag; otherwise je_en consumes it before any ALU write.
        if (ret_ok)             flag_next = pop_flag;
        else if (bus.je_en)     flag_next = 1'b0;
        else if (bus.flag_w_en) flag_next = bus.flag_in;
        else                    flag_next = flag_q;

        if (bus.jmp_en || (bus.je_en && flag_q)) seq_pc = bus.target;
        else                                     seq_pc = pc_q + PC_W'(1);

        cand_vld = 1'b0;
        cand     = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (bus.irq_req[i] && bus.irq_en[i]) begin
                cand_vld = 1'b1;
                cand     = ID_W'(i);
            end
        end
        cand_vld = cand_vld && bus.global_en;

        // On a return the ceiling is whatever the popped context was running.
        if (ret_ok) begin
            ceil_vld  = (level_q - LVL_W'(1)) != '0;
            ceil_id   = pop_id;
            eff_level = level_q - LVL_W'(1);
        end else begin
            ceil_vld  = level_q != '0;
            ceil_id   = active_id_q;
            eff_level = level_q;
        end

        take = cand_vld && (!ceil_vld || (cand < ceil_id)) && (eff_level < MAX_LVL);
        push = take && !ret_ok;

        pc_d        = seq_pc;
        flag_d      = flag_next;
        level_d     = level_q;
        active_id_d = active_id_q;
        irq_ack_d   = '0;
        ret_err_d   = ret_err_q || (bus.ret && !ret_ok);

        if (take) begin
            pc_d        = bus.irq_vec[int'(cand)*PC_W +: PC_W];
            active_id_d = cand;
            irq_ack_d   = N_IRQ'(1) << cand;
            if (!ret_ok) level_d = level_q + LVL_W'(1);
        end else if (ret_ok) begin
            pc_d        = pop_pc;
            flag_d      = pop_flag;
            active_id_d = pop_id;
            level_d     = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q        <= '0;
            flag_q      <= 1'b0;
            level_q     <= '0;
            active_id_q <= '0;
            irq_ack_q   <= '0;
            ret_err_q   <= 1'b0;
            for (int i = 0; i < NEST_DEPTH; i++) begin
                stk_pc_q[i]   <= '0;
                stk_flag_q[i] <= 1'b0;
                stk_id_q[i]   <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            flag_q      <= flag_d;
            level_q     <= level_d;
            active_id_q <= active_id_d;
            irq_ack_q   <= irq_ack_d;
            ret_err_q   <= ret_err_d;
            // Tail-chain leaves the stack alone: the popped frame stays as the return target.
            if (push) begin
                stk_pc_q[push_idx]   <= seq_pc;
                stk_flag_q[push_idx] <= flag_next;
                stk_id_q[push_idx]   <= active_id_q;
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.flag      = flag_q;
    assign bus.in_isr    = level_q != '0;
    assign bus.level     = level_q;
    assign bus.active_id = active_id_q;
    assign bus.irq_ack   = irq_ack_q;
    assign bus.ret_err   = ret_err_q;
endmodule

// File: tb/tb_jcr_seq_irq_unit.sv
// Bench for jcr_seq_irq_unit: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based model.
module tb_jcr_seq_irq_unit;
    localparam int PC_W = 8;
    localparam int N_IRQ = 4;
    localparam int NEST_DEPTH = 2;

    typedef struct {
        logic [7:0] pc;
        logic       flag;
        int         id;
    } frame_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic [7:0] vtab [4];

    logic [7:0] m_pc;
    logic       m_flag;
    int         m_id;
    logic [3:0] m_ack;
    logic       m_err;
    frame_t     stk [$];

    jcr_seq_irq_unit_if #(.PC_W(PC_W), .N_IRQ(N_IRQ), .NEST_DEPTH(NEST_DEPTH)) bus ();

    jcr_seq_irq_unit #(.PC_W(PC_W), .N_IRQ(N_IRQ), .NEST_DEPTH(NEST_DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < 4; i++) bus.irq_vec[i*8 +: 8] = vtab[i];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    // Reference: stack is a queue of frames, nesting level is simply its size.
    task automatic model_step();
        bit     valid_ret;
        frame_t top;
        int     ceil;
        int     c;
        int     post;
        bit     tk;
        logic   fn;
        logic [7:0] nxt;
        if (reset) begin
            m_pc = 0; m_flag = 0; m_id = 0; m_ack = 0; m_err = 0;
            stk.delete();
            return;
        end
        valid_ret = bus.ret && (stk.size() > 0);
        top = '{pc: 8'h00, flag: 1'b0, id: 0};
        if (valid_ret) top = stk[$];
        if (valid_ret) ceil = (stk.size() - 1 > 0) ? top.id : -1;
        else           ceil = (stk.size() > 0) ? m_id : -1;
        c = -1;
        if (bus.global_en)
            for (int i = N_IRQ - 1; i >= 0; i--)
                if (bus.irq_req[i] && bus.irq_en[i]) c = i;
        post = stk.size() - (valid_ret ? 1 : 0);
        tk = (c >= 0) && (ceil < 0 || c < ceil) && (post < NEST_DEPTH);
        fn = valid_ret ? top.flag : bus.je_en ? 1'b0 : bus.flag_w_en ? bus.flag_in : m_flag;
        nxt = (bus.jmp_en || (bus.je_en && m_flag)) ? bus.target : m_pc + 8'd1;
        m_ack = 0;
        if (bus.ret && !valid_ret) m_err = 1;
        if (tk) begin
            if (!valid_ret) stk.push_back('{pc: nxt, flag: fn, id: m_id});
            m_id = c; m_pc = vtab[c]; m_flag = fn; m_ack[c] = 1'b1;
        end else if (valid_ret) begin
            void'(stk.pop_back());
            m_pc = top.pc; m_flag = top.flag; m_id = top.id;
        end else begin
            m_pc = nxt; m_flag = fn;
        end
    endtask

    always @(posedge clock) begin
        model_step();
        #1;
        chk("m_pc", 32'(bus.pc), 32'(m_pc));
        chk("m_flag", 32'(bus.flag), 32'(m_flag));
        chk("m_level", 32'(bus.level), 32'(stk.size()));
        chk("m_in_isr", 32'(bus.in_isr), 32'(stk.size() > 0));
        chk("m_active_id", 32'(bus.active_id), 32'(m_id));
        chk("m_irq_ack", 32'(bus.irq_ack), 32'(m_ack));
        chk("m_ret_err", 32'(bus.ret_err), 32'(m_err));
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clr();
        bus.jmp_en = 0; bus.je_en = 0; bus.ret = 0;
        bus.flag_w_en = 0; bus.flag_in = 0; bus.target = 8'h00;
    endtask

    initial begin
        vtab[0] = 8'h08; vtab[1] = 8'h50; vtab[2] = 8'h30; vtab[3] = 8'h60;
        clr();
        bus.irq_req = 4'h0; bus.irq_en = 4'hF; bus.global_en = 1'b1;
        reset = 1'b1;
        tick(); tick();
        chk("rst_pc", 32'(bus.pc), 32'h0);
        chk("rst_level", 32'(bus.level), 32'h0);
        chk("rst_flag", 32'(bus.flag), 32'h0);
        chk("rst_ack", 32'(bus.irq_ack), 32'h0);
        reset = 1'b0;
        tick(); tick();
        chk("seq_pc", 32'(bus.pc), 32'h2);
        bus.jmp_en = 1; bus.target = 8'hFE; tick(); clr();
        chk("jmp_fe", 32'(bus.pc), 32'hFE);
        tick(); tick();
        chk("wrap", 32'(bus.pc), 32'h00);
        bus.jmp_en = 1; bus.target = 8'h05; tick(); clr();
        bus.flag_w_en = 1; bus.flag_in = 1; tick(); clr();
        chk("flag_set", 32'(bus.flag), 32'h1);
        chk("pc6", 32'(bus.pc), 32'h6);
        bus.je_en = 1; bus.target = 8'h40; tick();
        chk("je_taken", 32'(bus.pc), 32'h40);
        chk("je_clr", 32'(bus.flag), 32'h0);
        bus.target = 8'h80; tick(); clr();
        chk("je_not", 32'(bus.pc), 32'h41);
        bus.jmp_en = 1; bus.target = 8'h10; bus.flag_w_en = 1; bus.flag_in = 1; tick(); clr();
        bus.jmp_en = 1; bus.target = 8'h20; bus.irq_req = 4'b0100; tick(); clr();
        bus.irq_req = 4'h0;
        chk("irq2_pc", 32'(bus.pc), 32'h30);
        chk("irq2_ack", 32'(bus.irq_ack), 32'b0100);
        chk("irq2_lvl", 32'(bus.level), 32'h1);
        chk("irq2_id", 32'(bus.active_id), 32'h2);
        tick();
        chk("ack_pulse", 32'(bus.irq_ack), 32'h0);
        bus.irq_req = 4'b1000; tick();
        chk("no_preempt", 32'(bus.pc), 32'h32);
        bus.irq_req = 4'b1001; tick();
        chk("nest_pc", 32'(bus.pc), 32'h08);
        chk("nest_lvl", 32'(bus.level), 32'h2);
        chk("nest_id", 32'(bus.active_id), 32'h0);
        bus.irq_req = 4'b1010; tick();
        chk("depth_block", 32'(bus.pc), 32'h09);
        bus.irq_req = 4'h0; bus.ret = 1; tick(); clr();
        chk("ret2_pc", 32'(bus.pc), 32'h33);
        chk("ret2_id", 32'(bus.active_id), 32'h2);
        chk("ret2_lvl", 32'(bus.level), 32'h1);
        bus.irq_req = 4'b0010; bus.ret = 1; tick(); clr();
        bus.irq_req = 4'h0;
        chk("tail_pc", 32'(bus.pc), 32'h50);
        chk("tail_lvl", 32'(bus.level), 32'h1);
        chk("tail_id", 32'(bus.active_id), 32'h1);
        chk("tail_ack", 32'(bus.irq_ack), 32'b0010);
        tick();
        bus.ret = 1; tick(); clr();
        chk("ret1_pc", 32'(bus.pc), 32'h20);
        chk("ret1_lvl", 32'(bus.level), 32'h0);
        chk("ret1_flag", 32'(bus.flag), 32'h1);
        bus.ret = 1; tick(); clr();
        chk("ret_err", 32'(bus.ret_err), 32'h1);
        chk("ret_err_pc", 32'(bus.pc), 32'h21);
        bus.irq_req = 4'b0100; tick();
        bus.irq_req = 4'b0001; tick();
        bus.irq_req = 4'h0;
        chk("lvl2", 32'(bus.level), 32'h2);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_mid_pc", 32'(bus.pc), 32'h0);
        chk("rst_mid_lvl", 32'(bus.level), 32'h0);
        chk("rst_mid_err", 32'(bus.ret_err), 32'h0);
        bus.ret = 1; tick(); clr();
        chk("rst_stack_empty", 32'(bus.ret_err), 32'h1);

        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            bus.jmp_en = ($urandom_range(0, 7) == 0);
            bus.je_en = ($urandom_range(0, 5) == 0);
            bus.ret = ($urandom_range(0, 5) == 0);
            bus.flag_w_en = ($urandom_range(0, 3) == 0);
            bus.flag_in = 1'($urandom_range(0, 1));
            bus.target = 8'($urandom_range(0, 255));
            bus.irq_req = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            bus.irq_en = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            bus.global_en = ($urandom_range(0, 15) != 0);
            tick();
        end
        reset = 1'b0;
        clr();
        bus.irq_req = 4'h0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
